// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - shared types and helpers for the pattern generator
package seq_gen_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PINGPONG = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Zero or oversize lengths collapse to the full table.
    function automatic int unsigned sanitise_len(int unsigned len, int unsigned depth);
        return (len == 0 || len > depth) ? depth : len;
    endfunction

    function automatic mode_e sanitise_mode(logic [1:0] m);
        case (m)
            2'd1:    return MODE_ONESHOT;
            2'd2:    return MODE_PINGPONG;
            default: return MODE_LOOP;
        endcase
    endfunction

endpackage

// File: rtl/seq_idx_ctrl.sv
// rtl/seq_idx_ctrl.sv - next index and direction for the active traversal mode
module seq_idx_ctrl
    import seq_gen_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic [AW-1:0] idx,
    input  logic          dir,
    input  logic [1:0]    mode_q,
    input  logic [AW:0]   len_q,
    output logic [AW-1:0] next_idx,
    output logic          next_dir,
    output logic          at_last,
    output logic          at_end
);

    logic [AW:0] top_w;
    logic        at_top;

    assign top_w  = len_q - (AW+1)'(1);
    assign at_top = ({1'b0, idx} == top_w);

    always_comb begin
        next_idx = idx;
        next_dir = dir;
        case (mode_q)
            MODE_PINGPONG: begin
                if (len_q == (AW+1)'(1)) begin
                    next_idx = '0;
                    next_dir = 1'b0;
                end else if (!dir) begin
                    // Turn at the top so the endpoint is emitted only once.
                    if (at_top) begin
                        next_idx = idx - AW'(1);
                        next_dir = 1'b1;
                    end else begin
                        next_idx = idx + AW'(1);
                    end
                end else begin
                    if (idx == '0) begin
                        next_idx = AW'(1);
                        next_dir = 1'b0;
                    end else begin
                        next_idx = idx - AW'(1);
                    end
                end
            end
            MODE_ONESHOT: begin
                if (!at_top)
                    next_idx = idx + AW'(1);
            end
            default: begin
                next_idx = at_top ? '0 : idx + AW'(1);
            end
        endcase
    end

    assign at_last = !dir && at_top;
    assign at_end  = at_last && (mode_q == MODE_ONESHOT);

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - programmable table pattern streamer with valid/ready
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int                      DATA_W = 8,
    parameter int                      DEPTH  = 8,
    parameter logic [DATA_W*DEPTH-1:0] INIT   = 64'h8D0BE2FF78E2BCAF,
    localparam int                     AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              restart,
    input  logic [1:0]        mode,
    input  logic [AW:0]       len,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              last,
    output logic              done
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] tbl_q [DEPTH];
    state_e            state_q;
    mode_e             mode_q;
    logic [AW:0]       len_q;
    logic [AW-1:0]     idx_q;
    logic              dir_q;
    logic              valid_q;
    logic              done_q;

    logic [AW-1:0]     next_idx;
    logic              next_dir;
    logic              at_last;
    logic              at_end;
    logic              fire;
    logic [AW:0]       len_s;

    assign fire  = valid_q & ready;
    assign len_s = (AW+1)'(sanitise_len(32'(len), DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                tbl_q[i] <= INIT[i*DATA_W +: DATA_W];
        end else if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
            tbl_q[wr_addr] <= wr_data;
        end
    end

    seq_idx_ctrl #(.AW(AW)) u_idx_ctrl (
        .idx      (idx_q),
        .dir      (dir_q),
        .mode_q   (mode_q),
        .len_q    (len_q),
        .next_idx (next_idx),
        .next_dir (next_dir),
        .at_last  (at_last),
        .at_end   (at_end)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_LOOP;
            len_q   <= DEPTH_W;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (restart) begin
            state_q <= ST_IDLE;
            mode_q  <= sanitise_mode(mode);
            len_q   <= len_s;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_RUN;
                        valid_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (fire && at_end) begin
                        state_q <= ST_DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        // An accepted word still advances when enable drops alongside it.
                        if (fire) begin
                            idx_q <= next_idx;
                            dir_q <= next_dir;
                        end
                        if (!enable) begin
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign data  = tbl_q[idx_q];
    assign valid = valid_q;
    assign last  = valid_q & at_last;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - directed self-checking bench for seq_pattern_gen
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] len = 4'd0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'd0;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    seq_pattern_gen dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .restart (restart),
        .mode    (mode),
        .len     (len),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .last    (last),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: position in the output sequence is a count of accepted words.
    logic [7:0] m_tab [8];
    int         m_mode;
    int         m_len;
    int         m_k;
    bit         m_valid;
    bit         m_done;

    function automatic int m_idx();
        int p;
        if (m_mode == 2) begin
            if (m_len == 1)
                return 0;
            p = m_k % (2 * (m_len - 1));
            return (p < m_len) ? p : 2 * (m_len - 1) - p;
        end else if (m_mode == 1) begin
            return (m_k < m_len) ? m_k : m_len - 1;
        end
        return m_k % m_len;
    endfunction

    task automatic m_reset();
        logic [63:0] init_v;
        init_v = 64'h8D0BE2FF78E2BCAF;
        for (int i = 0; i < 8; i++)
            m_tab[i] = init_v[i*8 +: 8];
        m_mode  = 0;
        m_len   = 8;
        m_k     = 0;
        m_valid = 1'b0;
        m_done  = 1'b0;
    endtask

    initial begin
        int  ei;
        bit  fire;
        m_reset();
        forever begin
            @(negedge clk);
            if (!reset_n)
                m_reset();
            ei = m_idx();
            check("model_data", data, m_tab[ei]);
            check("model_valid", valid, m_valid);
            check("model_last", last, m_valid && (ei == m_len - 1));
            check("model_done", done, m_done);
            if (reset_n) begin
                fire = m_valid && ready;
                if (wr_en)
                    m_tab[wr_addr] = wr_data;
                if (restart) begin
                    m_mode  = (mode == 2'd3) ? 0 : int'(mode);
                    m_len   = (len == 0 || len > 8) ? 8 : int'(len);
                    m_k     = 0;
                    m_valid = 1'b0;
                    m_done  = 1'b0;
                end else if (!m_done) begin
                    if (fire) begin
                        if (m_mode == 1 && ei == m_len - 1) begin
                            m_done  = 1'b1;
                            m_valid = 1'b0;
                        end else begin
                            m_k++;
                        end
                    end
                    if (!m_done)
                        m_valid = enable;
                end
            end
        end
    end

    initial begin
        logic [7:0] exp1 [9];
        logic [7:0] exp4 [8];
        exp1 = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D, 8'hAF};
        exp4 = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hE2, 8'hBC, 8'hAF, 8'hBC};

        #1 reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        check("rst_data", data, 8'hAF);
        check("rst_valid", valid, 1'b0);
        check("rst_last", last, 1'b0);
        check("rst_done", done, 1'b0);

        // Free-running loop over the reset table
        enable = 1'b1;
        ready  = 1'b1;
        step();
        check("first_valid", valid, 1'b1);
        for (int i = 0; i < 9; i++) begin
            check("loop_data", data, exp1[i]);
            check("loop_last", last, (i == 7));
            step();
        end

        // Backpressure holds the word
        step();
        check("stall_pre", data, 8'hE2);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_data", data, 8'hE2);
            check("stall_valid", valid, 1'b1);
        end
        ready = 1'b1;
        step();
        check("resume_data", data, 8'h78);

        // One-shot of three entries
        restart = 1'b1;
        mode    = 2'd1;
        len     = 4'd3;
        step();
        restart = 1'b0;
        check("os_idle_valid", valid, 1'b0);
        step();
        check("os_d0", data, 8'hAF);
        step();
        check("os_d1", data, 8'hBC);
        step();
        check("os_d2", data, 8'hE2);
        check("os_last", last, 1'b1);
        step();
        check("os_valid_off", valid, 1'b0);
        check("os_done", done, 1'b1);
        for (int i = 0; i < 4; i++) begin
            enable = (i % 2 == 1);
            step();
        end
        enable = 1'b1;
        step();
        check("os_hold_valid", valid, 1'b0);
        check("os_hold_done", done, 1'b1);
        check("os_hold_data", data, 8'hE2);

        // Ping-pong over four entries, then a single entry
        restart = 1'b1;
        mode    = 2'd2;
        len     = 4'd4;
        step();
        restart = 1'b0;
        check("pp_done_clr", done, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            check("pp_data", data, exp4[i]);
            step();
        end
        restart = 1'b1;
        len     = 4'd1;
        step();
        restart = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            check("pp1_data", data, 8'hAF);
            check("pp1_last", last, 1'b1);
            step();
        end

        // Run-time table writes, len=0 meaning full table
        restart = 1'b1;
        mode    = 2'd0;
        len     = 4'd0;
        step();
        restart = 1'b0;
        step(2);
        check("wr_pre", data, 8'hBC);
        ready   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 8'h55;
        step();
        wr_en = 1'b0;
        check("wr_same_idx", data, 8'h55);
        ready   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 8'h66;
        step();
        wr_en = 1'b0;
        check("wr_and_fire", data, 8'h66);
        step(5);
        check("len0_d7", data, 8'h8D);
        check("len0_last", last, 1'b1);

        // Asynchronous reset mid-stream restores the table
        step();
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", valid, 1'b0);
        check("arst_data", data, 8'hAF);
        check("arst_done", done, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        step();
        check("post_rst_d0", data, 8'hAF);
        step();
        check("post_rst_reload", data, 8'hBC);

        // Reserved mode behaves as loop
        restart = 1'b1;
        mode    = 2'd3;
        len     = 4'd0;
        step();
        restart = 1'b0;
        step();
        check("rsv_d0", data, 8'hAF);
        step(7);
        check("rsv_d7", data, 8'h8D);
        check("rsv_last", last, 1'b1);
        step();
        check("rsv_wrap", data, 8'hAF);
        check("rsv_wrap_last", last, 1'b0);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
